panel_input_conditioner: RTL and testbench

Front-panel input stage of the board-level top, sitting directly upstream of the processor and the 16-bit display selector. It synchronizes and debounces the raw EXEC push-button, the 16-bit DIP-switch bank and the 4-bit rotary display switch. It delivers a clean `exec` level, a single-cycle `exec_pulse`, a stable `outside_input` word and a stable `select_display` code. All outputs are glitch-free, registered, and change only after a full debounce window.

---
 rtl/panel_input_pkg.sv | 21 ++
 rtl/stable_filter.sv | 49 ++++
 rtl/panel_input_conditioner.sv | 127 ++++++++++++
 tb/tb_panel_input_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/panel_input_pkg.sv
// panel_input_pkg: shared types and constants for the front-panel input stage.
//   btn_state_t  - EXEC button debounce FSM states
//   DEFAULT_*    - default debounce window and synchronizer depth
//   cnt_width()  - width of a counter that must reach cycles-1
package panel_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/stable_filter.sv
// stable_filter: synchronizes a multi-bit asynchronous input and only
// forwards a new value once it has been held for DEBOUNCE_CYCLES cycles.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   raw[WIDTH]    - asynchronous input word
//   stable[WIDTH] - registered, debounced copy of raw
module stable_filter
  import panel_input_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      stable <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (sync_q[SYNC_STAGES-1] != cand_q) begin
        cand_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
        // The reload cycle already counts as the first stable cycle, so the
        // value is accepted as the counter steps onto its saturation value.
        if (cnt_q == CNT_LOAD) stable <= cand_q;
      end
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// panel_input_conditioner: front-panel input stage. Synchronizes and
// debounces the EXEC button, the 16-bit DIP-switch bank and the rotary
// display selector.
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   exec_button         - raw EXEC push-button (high while pressed)
//   switch_raw[16]      - raw DIP switches
//   rotary_raw[4]       - raw rotary display-select switch
//   exec                - run level to the processor
//   exec_pulse          - one-cycle strobe per accepted press
//   outside_input[16]   - debounced switch word
//   select_display[4]   - debounced display selector
// Build option: define EXEC_TOGGLE_EN to make exec a run/halt latch that
// inverts on every exec_pulse; otherwise exec is the debounced button level.
module panel_input_conditioner
  import panel_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec_button,
  input  logic [15:0] switch_raw,
  input  logic [3:0]  rotary_raw,
  output logic        exec,
  output logic        exec_pulse,
  output logic [15:0] outside_input,
  output logic [3:0]  select_display
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   btn_synced;
  btn_state_t             state_q, state_next;
  logic [CNT_W-1:0]       cnt_q, cnt_next;
  logic                   pulse_next;
  logic                   exec_next;

  assign btn_synced = btn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      exec_pulse <= 1'b0;
      exec       <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], exec_button};
      state_q    <= state_next;
      cnt_q      <= cnt_next;
      exec_pulse <= pulse_next;
      exec       <= exec_next;
    end
  end

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    pulse_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_synced) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_synced) begin
          state_next = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_synced) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_synced) begin
          state_next = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef EXEC_TOGGLE_EN
    exec_next = exec ^ pulse_next;
`else
    exec_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
`endif
  end

  stable_filter #(
    .WIDTH          (16),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_switch_filter (
    .clock (clock),
    .reset (reset),
    .raw   (switch_raw),
    .stable(outside_input)
  );

  stable_filter #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rotary_filter (
    .clock (clock),
    .reset (reset),
    .raw   (rotary_raw),
    .stable(select_display)
  );

endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb_panel_input_conditioner: directed bench for panel_input_conditioner
// with DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Expected exec values follow the
// EXEC_TOGGLE_EN build option.
module tb_panel_input_conditioner;

  logic        clock;
  logic        reset;
  logic        exec_button;
  logic [15:0] switch_raw;
  logic [3:0]  rotary_raw;
  logic        exec;
  logic        exec_pulse;
  logic [15:0] outside_input;
  logic [3:0]  select_display;

  int tests = 0;
  int fails = 0;
  int p, p2;
  logic exec_t;

`ifdef EXEC_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .exec_button   (exec_button),
    .switch_raw    (switch_raw),
    .rotary_raw    (rotary_raw),
    .exec          (exec),
    .exec_pulse    (exec_pulse),
    .outside_input (outside_input),
    .select_display(select_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      pulses += int'(exec_pulse);
    end
  endtask

  initial begin
    reset = 1'b1; exec_button = 1'b0; switch_raw = '0; rotary_raw = '0;
    exec_t = 1'b0;
    tick(); tick();
    check("rst_exec", 16'(exec), 16'h0);
    check("rst_pulse", 16'(exec_pulse), 16'h0);
    check("rst_outside", outside_input, 16'h0000);
    check("rst_select", 16'(select_display), 16'h0);

    reset = 1'b0;
    run_count(10, p);
    check("idle_pulses", 16'(p), 16'd0);
    check("idle_exec", 16'(exec), 16'h0);
    check("idle_outside", outside_input, 16'h0000);
    check("idle_select", 16'(select_display), 16'h0);

    // Clean press: pulse only after edge 7
    exec_button = 1'b1;
    run_count(6, p);
    check("press_early_pulses", 16'(p), 16'd0);
    check("press_early_exec", 16'(exec), 16'h0);
    tick();
    check("press_pulse", 16'(exec_pulse), 16'h1);
    check("press_exec", 16'(exec), 16'h1);
    exec_t = 1'b1;
    tick();
    check("press_pulse_end", 16'(exec_pulse), 16'h0);
    run_count(18, p);
    check("press_hold_pulses", 16'(p), 16'd0);
    check("press_hold_exec", 16'(exec), 16'h1);

    // Clean release: level drops at edge 7 in level mode, never a pulse
    exec_button = 1'b0;
    run_count(6, p);
    check("rel_exec_early", 16'(exec), 16'h1);
    tick();
    p += int'(exec_pulse);
    check("rel_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h0);
    run_count(10, p2);
    check("rel_pulses", 16'(p + p2), 16'd0);

    // Bouncing press
    exec_button = 1'b1; run_count(2, p);
    exec_button = 1'b0; run_count(2, p2); p += p2;
    exec_button = 1'b1; run_count(6, p2); p += p2;
    check("bounce_early_pulses", 16'(p), 16'd0);
    tick();
    check("bounce_pulse", 16'(exec_pulse), 16'h1);
    exec_t = ~exec_t;
    check("bounce_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h1);
    run_count(10, p);
    check("bounce_hold_pulses", 16'(p), 16'd0);

    // Bouncing release
    exec_button = 1'b0; run_count(2, p);
    exec_button = 1'b1; run_count(2, p2); p += p2;
    exec_button = 1'b0; run_count(15, p2); p += p2;
    check("bounce_rel_pulses", 16'(p), 16'd0);
    check("bounce_rel_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h0);

    // Switches
    switch_raw = 16'h00A5;
    run_count(10, p);
    check("sw_settle", outside_input, 16'h00A5);
    switch_raw = 16'h1234;
    repeat (5) tick();
    check("sw_early", outside_input, 16'h00A5);
    tick();
    check("sw_edge6", outside_input, 16'h1234);
    repeat (4) tick();
    switch_raw = 16'hFFFF;
    repeat (3) tick();
    switch_raw = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("sw_glitch3", outside_input, 16'h1234);
    end
    switch_raw = 16'hFFFF;
    repeat (4) tick();
    switch_raw = 16'h1234;
    repeat (2) tick();
    check("sw_change4", outside_input, 16'hFFFF);
    repeat (10) tick();
    check("sw_back", outside_input, 16'h1234);

    // Rotary change together with a press
    rotary_raw = 4'h7; exec_button = 1'b1;
    repeat (5) tick();
    check("rot_early", 16'(select_display), 16'h0);
    tick();
    check("rot_edge6", 16'(select_display), 16'h7);
    check("rot_pulse_early", 16'(exec_pulse), 16'h0);
    tick();
    check("rot_press_pulse", 16'(exec_pulse), 16'h1);
    exec_t = ~exec_t;
    check("rot_press_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h1);
    exec_button = 1'b0;
    repeat (10) tick();

    // Reset in the middle of PRESS_WAIT
    exec_button = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pulse", 16'(exec_pulse), 16'h0);
    check("mid_rst_exec", 16'(exec), 16'h0);
    check("mid_rst_outside", outside_input, 16'h0000);
    check("mid_rst_select", 16'(select_display), 16'h0);
    exec_t = 1'b0;
    tick(); tick();
    reset = 1'b0;
    run_count(6, p);
    check("requal_early_pulses", 16'(p), 16'd0);
    check("requal_outside", outside_input, 16'h1234);
    check("requal_select", 16'(select_display), 16'h7);
    tick();
    check("requal_pulse", 16'(exec_pulse), 16'h1);
    exec_t = 1'b1;
    check("requal_exec", 16'(exec), 16'h1);
    exec_button = 1'b0;
    repeat (10) tick();
    check("requal_rel_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h0);

    // Second full press
    exec_button = 1'b1;
    run_count(6, p);
    check("second_early_pulses", 16'(p), 16'd0);
    tick();
    check("second_pulse", 16'(exec_pulse), 16'h1);
    exec_t = ~exec_t;
    check("second_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h1);
    exec_button = 1'b0;
    repeat (10) tick();
    check("second_rel_exec", 16'(exec), TOGGLE ? 16'(exec_t) : 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
